// File: rtl/bird_physics_if.sv
// bird_physics_if: controller <-> bird physics signal bundle.
// master = game controller, slave = bird_physics.
interface bird_physics_if;
    logic       enable;
    logic       restart;
    logic       flap_button;
    logic [9:0] bird_y;
    logic [7:0] bird_vel;
    logic       frame_tick;
    logic       hit_floor;
    logic       hit_ceiling;

    modport master (
        output enable, restart, flap_button,
        input  bird_y, bird_vel, frame_tick, hit_floor, hit_ceiling
    );

    modport slave (
        input  enable, restart, flap_button,
        output bird_y, bird_vel, frame_tick, hit_floor, hit_ceiling
    );
endinterface

// File: rtl/bird_physics.sv
// bird_physics: per-frame gravity/flap integrator for the bird's vertical position.
// Define FLAP_SYNC_EN to pass flap_button through a 2-flop synchronizer first.
module bird_physics #(
    parameter int SCREEN_HEIGHT  = 480,
    parameter int BIRD_HEIGHT    = 20,
    parameter int BIRD_Y_START   = 230,
    parameter int GRAVITY        = 1,
    parameter int FLAP_VELOCITY  = 8,
    parameter int MAX_FALL_SPEED = 10,
    parameter int FRAME_DIV      = 833333
) (
    input logic           clk,
    input logic           reset,
    bird_physics_if.slave bp
);
    localparam int CW = $clog2(FRAME_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
    localparam logic [11:0] FLOOR_Y = 12'(SCREEN_HEIGHT - BIRD_HEIGHT);
    localparam logic [9:0] Y_START = 10'(BIRD_Y_START);
    localparam logic signed [11:0] GRAV_S = 12'(GRAVITY);
    localparam logic signed [11:0] MAXF_S = 12'(MAX_FALL_SPEED);
    localparam logic signed [7:0] FLAP_S = 8'(-FLAP_VELOCITY);

    typedef enum logic [1:0] {IDLE, FLY, GROUNDED} state_t;

    state_t r_state;
    logic [CW-1:0] r_cnt;
    logic r_tick;
    logic [9:0] r_y;
    logic signed [7:0] r_vel;
    logic r_pend;
    logic r_prev;
    logic r_hf;
    logic r_hc;

    logic w_btn;
    logic w_edge;
    logic w_flap;
    logic signed [11:0] w_vg;
    logic signed [7:0] w_vn;
    logic [11:0] w_yn;
    logic w_ceil;
    logic w_floor;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

`ifdef FLAP_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], bp.flap_button};
    end

    assign w_btn = r_sync[1];
`else
    assign w_btn = bp.flap_button;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_prev <= 1'b0;
        else        r_prev <= w_btn;
    end

    // An edge arriving on the update cycle is folded straight into that update.
    assign w_edge = w_btn & ~r_prev & bp.enable & (r_state != GROUNDED);
    assign w_flap = r_pend | w_edge;

    assign w_vg = {{4{r_vel[7]}}, r_vel} + GRAV_S;
    assign w_vn = w_flap ? FLAP_S
                : ((w_vg > MAXF_S) ? MAXF_S[7:0] : w_vg[7:0]);
    assign w_yn = {2'b00, r_y} + {{4{w_vn[7]}}, w_vn};
    assign w_ceil = w_yn[11];
    assign w_floor = !w_yn[11] && (w_yn >= FLOOR_Y);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_y     <= Y_START;
            r_vel   <= '0;
            r_pend  <= 1'b0;
            r_hf    <= 1'b0;
            r_hc    <= 1'b0;
        end else begin
            r_hc <= 1'b0;
            if (bp.restart) begin
                r_state <= IDLE;
                r_y     <= Y_START;
                r_vel   <= '0;
                r_pend  <= 1'b0;
                r_hf    <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_edge) r_pend <= 1'b1;
                        if (bp.enable) r_state <= FLY;
                    end
                    FLY: begin
                        if (r_tick && bp.enable) begin
                            r_pend <= 1'b0;
                            unique case (1'b1)
                                w_ceil: begin
                                    r_y   <= '0;
                                    r_vel <= '0;
                                    r_hc  <= 1'b1;
                                end
                                w_floor: begin
                                    r_y     <= FLOOR_Y[9:0];
                                    r_vel   <= '0;
                                    r_hf    <= 1'b1;
                                    r_state <= GROUNDED;
                                end
                                default: begin
                                    r_y   <= w_yn[9:0];
                                    r_vel <= w_vn;
                                end
                            endcase
                        end else if (w_edge) begin
                            r_pend <= 1'b1;
                        end
                    end
                    GROUNDED: r_pend <= 1'b0;
                    default:  r_state <= IDLE;
                endcase
            end
        end
    end

    assign bp.bird_y      = r_y;
    assign bp.bird_vel    = r_vel;
    assign bp.frame_tick  = r_tick;
    assign bp.hit_floor   = r_hf;
    assign bp.hit_ceiling = r_hc;
endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Upstream stage of the game controller; produces the bird's vertical position `bird_y` that the controller and collision logic consume.
- Integrates gravity and flap impulses once per frame tick.
- Generates the frame tick internally.
- Reports floor/ceiling contact so the controller can end or clamp play.

Parameters:
- SCREEN_HEIGHT, 480, screen height in pixels.
- BIRD_HEIGHT, 20, bird height in pixels; floor limit = SCREEN_HEIGHT-BIRD_HEIGHT (460).
- BIRD_Y_START, 230, `bird_y` after reset or restart.
- GRAVITY, 1, velocity increment per frame (pixels/frame).
- FLAP_VELOCITY, 8, upward speed magnitude applied on a flap.
- MAX_FALL_SPEED, 10, downward velocity ceiling.
- FRAME_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz); minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  high while the controller is in play state; low freezes motion
- restart  input  1  one-cycle pulse: return bird to start position
- flap_button  input  1  raw button level
- bird_y  output  10  top edge of bird, pixels, 0 = top
- bird_vel  output  8  signed velocity, positive = downward
- frame_tick  output  1  one-cycle pulse per frame
- hit_floor  output  1  level, high while grounded
- hit_ceiling  output  1  one-cycle pulse when clamped at y=0

Behaviour:
- Reset (reset=0, async) forces:
  - `bird_y`=BIRD_Y_START, `bird_vel`=0, frame counter=0, `frame_tick`=0, `hit_floor`=0, `hit_ceiling`=0
  - flap pending=0, edge-detect register=0, state=IDLE.
- Frame counter:
  - Counts 0..FRAME_DIV-1 continuously, independent of `enable`.
  - `frame_tick`=1 in the cycle after the counter reaches FRAME_DIV-1; the counter wraps to 0 at that point.
  - `restart` does not reset the counter.
- Flap detect:
  - Rising edge of `flap_button` (registered previous value) sets flap pending.
  - Pending is cleared on the cycle it is consumed.
  - An edge in the same cycle as the update tick counts for that tick.
  - Multiple edges within one frame = one flap.
  - Edges while `enable`=0 are discarded.
- States:
  - IDLE: y and vel held at start values. Exits to FLY when `enable`=1.
  - FLY: on each `frame_tick` with `enable`=1, perform the update below. `enable`=0 freezes y/vel but stays in FLY.
  - GROUNDED: `hit_floor`=1. y fixed at floor limit, vel=0, flaps ignored. Exit only via `restart` or reset.
- Update, registered; outputs change one cycle after `frame_tick`:
  - Velocity first: vel' = flap ? -FLAP_VELOCITY : min(vel+GRAVITY, MAX_FALL_SPEED).
  - Then position: y' = y + vel', computed in 12-bit signed.
  - If y' < 0: y=0, vel=0, `hit_ceiling` pulse 1 cycle.
  - If y' >= floor limit: y=floor limit, vel=0, go to GROUNDED.
  - Otherwise y = y'.
- `restart` priority: restart > tick update > flap capture.
  - Restart sets y=BIRD_Y_START, vel=0, clears pending, `hit_floor`=0, state=IDLE, next cycle.
- Widths: velocity saturates by construction within signed 8 bits; no wrap allowed. `bird_y` is never outside 0..floor limit.
- Reset asserted mid-frame: everything returns to reset values immediately, with no partial update.

Optional Feature:
- Macro: FLAP_SYNC_EN.
- Defined: `flap_button` passes through a 2-flop synchronizer before edge detection, adding 2 cycles of latency from button to pending.
- Undefined: edge detection samples `flap_button` directly (input assumed synchronous); pending is set the cycle after the edge.
- All other behaviour is identical in both builds.

Test Plan (FRAME_DIV=4, FLAP_SYNC_EN undefined unless stated):
- Gravity: release reset, `enable`=1, no flap → after ticks 1/2/3, vel=1/2/3 and `bird_y`=231/233/236; `frame_tick` period exactly 4 cycles.
- Flap with velocity preset: from y=236, vel=3, a flap edge mid-frame → next update vel=-8, y=228; two edges in the same frame → identical result.
- Ceiling clamp: drive y near top via repeated flaps until y=5, flap again → y=0, vel=0, `hit_ceiling` high exactly 1 cycle.
- Floor: free-fall from start → vel saturates at 10, y clamps at 460, `hit_floor`=1, later flaps ignored; `restart` → y=230, vel=0, `hit_floor`=0, state IDLE.
- Freeze and simultaneity:
  - `enable`=0 across 3 ticks → y/vel unchanged, flap edges discarded.
  - `restart` coincident with `frame_tick` and a flap → restart wins, y=230.
- Async reset and sync build: assert reset mid-frame at y=300 → outputs immediately at reset values; with FLAP_SYNC_EN defined, pending asserts 3 cycles after the button edge instead of 1.
